ibuf2ddr: RTL and testbench

Read-back path for the PE index buffers: on `start`, reads `conf_idx_num+1` index pairs from one selected PE's index buffer, packs them into DDR-width words and streams them out on a valid/ready interface toward the DDR write engine. It is the inverse of the DDR-to-index-buffer loader. Applying the same `conf_mode` and `conf_idx_num` to both directions round-trips the buffer contents bit-exactly.

---
 rtl/ibuf2ddr_pkg.sv | 26 ++
 rtl/ibuf2ddr_if.sv | 18 +
 rtl/idx_word_packer.sv | 47 ++++
 rtl/ibuf2ddr.sv | 188 ++++++++++++++++++
 tb/tb_ibuf2ddr.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ibuf2ddr_pkg.sv
// ibuf2ddr_pkg: constants and types shared by the index-buffer <-> DDR movers.
//   IDX_W / DDR_W  : index and DDR word widths
//   IDX_BATCH      : index pairs packed per DDR word
//   IDX_MODE_SWAP  : conf_mode[2:1] value selecting half-swap (loader and read-back alike)
//   ibuf2ddr_state_t : read-back FSM states
package ibuf2ddr_pkg;

    localparam int unsigned IDX_W     = 16;
    localparam int unsigned DDR_W     = 256;
    localparam int unsigned IDX_BATCH = DDR_W / IDX_W / 2;

    localparam logic [1:0] IDX_MODE_SWAP = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StSend
    } ibuf2ddr_state_t;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned bw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ibuf2ddr_if.sv
// ibuf2ddr_if: valid/ready DDR word stream.
//   data  : packed DDR word
//   valid : word valid (source)
//   last  : final word of the stream (source)
//   ready : accept (sink)
interface ibuf2ddr_if #(
    parameter int unsigned DataW = 256
) ();

    logic [DataW-1:0] data;
    logic             valid;
    logic             last;
    logic             ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/idx_word_packer.sv
// idx_word_packer: lane-addressed DDR word register.
//   clk, rst_n : clock, async active-low reset (word clears to 0)
//   clr_i      : zero the whole word (takes priority over a write)
//   wr_en_i    : write wr_data_i into lane wr_lane_i
//   wr_lane_i  : lane index, lane k = word_o[k*2*IDX_W +: 2*IDX_W]
//   wr_data_i  : one index pair
//   word_o     : current word
module idx_word_packer
    import ibuf2ddr_pkg::*;
#(
    parameter int unsigned LaneW = bw(IDX_BATCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 wr_en_i,
    input  logic [LaneW-1:0]     wr_lane_i,
    input  logic [2*IDX_W-1:0]   wr_data_i,
    output logic [DDR_W-1:0]     word_o
);

    logic [DDR_W-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (wr_en_i) begin
            for (int k = 0; k < IDX_BATCH; k++) begin
                if (wr_lane_i == LaneW'(k)) begin
                    word_d[k*2*IDX_W +: 2*IDX_W] = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/ibuf2ddr.sv
// ibuf2ddr: reads conf_idx_num+1 index pairs from one PE index buffer, packs IDX_BATCH pairs per
// DDR word and streams the words out. Inverse of the DDR-to-index-buffer loader.
//   clk, rst_n      : clock, async active-low reset
//   start_i         : one-cycle start, sampled only when idle
//   done_o          : idle/finished flag
//   conf_mode_i     : [2:1] == IDX_MODE_SWAP stores each pair half-swapped
//   conf_idx_num_i  : last entry index (entries = value + 1)
//   conf_pe_sel_i   : PE buffer to read
//   idx_rd_addr_o   : buffer read address
//   idx_rd_en_o     : one-hot PE read enable
//   idx_rd_data_i   : all PE read ports, PE 0 at LSB, 1-cycle latency
//   ddr             : outgoing word stream (master)
module ibuf2ddr
    import ibuf2ddr_pkg::*;
#(
    parameter int unsigned IDX_DEPTH = 256,
    parameter int unsigned ADDR_W    = bw(IDX_DEPTH),
    parameter int unsigned PE_NUM    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    output logic                        done_o,
    input  logic [3:0]                  conf_mode_i,
    input  logic [7:0]                  conf_idx_num_i,
    input  logic [bw(PE_NUM)-1:0]       conf_pe_sel_i,
    output logic [ADDR_W-1:0]           idx_rd_addr_o,
    output logic [PE_NUM-1:0]           idx_rd_en_o,
    input  logic [PE_NUM*IDX_W*2-1:0]   idx_rd_data_i,
    ibuf2ddr_if.master                  ddr
);

    localparam int unsigned PeW   = bw(PE_NUM);
    localparam int unsigned LaneW = bw(IDX_BATCH);

    ibuf2ddr_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;          // entries issued so far in this job
    logic [LaneW-1:0]  lane_q, lane_d;
    logic [7:0]        idx_num_q, idx_num_d;
    logic [PeW-1:0]    pe_sel_q, pe_sel_d;
    logic              swap_q, swap_d;
    logic              last_word_q, last_word_d;
    logic              done_q, done_d;
    // Read data returns one cycle after issue; remember which lane it belongs to.
    logic              cap_vld_q, cap_vld_d;
    logic [LaneW-1:0]  cap_lane_q, cap_lane_d;

    logic                 pack_clr;
    logic [2*IDX_W-1:0]   rd_pair;
    logic [2*IDX_W-1:0]   wr_pair;
    logic [DDR_W-1:0]     word;
    logic                 last_entry;

    logic unused_mode;
    assign unused_mode = ^{conf_mode_i[3], conf_mode_i[0]};

    assign last_entry = (cnt_q == idx_num_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        idx_num_d   = idx_num_q;
        pe_sel_d    = pe_sel_q;
        swap_d      = swap_q;
        last_word_d = last_word_q;
        done_d      = done_q;
        cap_vld_d   = (state_q == StRead);
        cap_lane_d  = lane_q;
        pack_clr    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StRead;
                    idx_num_d   = conf_idx_num_i;
                    pe_sel_d    = conf_pe_sel_i;
                    swap_d      = (conf_mode_i[2:1] == IDX_MODE_SWAP);
                    addr_d      = '0;
                    cnt_d       = '0;
                    lane_d      = '0;
                    last_word_d = 1'b0;
                    done_d      = 1'b0;
                    pack_clr    = 1'b1;
                end
            end
            StRead: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                lane_d = lane_q + 1'b1;
                if (lane_q == LaneW'(IDX_BATCH - 1) || last_entry) begin
                    state_d     = StDrain;
                    lane_d      = '0;
                    last_word_d = last_entry;
                end
            end
            StDrain: begin
                state_d = StSend;
            end
            StSend: begin
                if (ddr.ready) begin
                    if (last_word_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StRead;
                        pack_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            lane_q      <= '0;
            idx_num_q   <= '0;
            pe_sel_q    <= '0;
            swap_q      <= 1'b0;
            last_word_q <= 1'b0;
            done_q      <= 1'b1;
            cap_vld_q   <= 1'b0;
            cap_lane_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            idx_num_q   <= idx_num_d;
            pe_sel_q    <= pe_sel_d;
            swap_q      <= swap_d;
            last_word_q <= last_word_d;
            done_q      <= done_d;
            cap_vld_q   <= cap_vld_d;
            cap_lane_q  <= cap_lane_d;
        end
    end

    // Select the latched PE's read port.
    always_comb begin
        rd_pair = '0;
        for (int p = 0; p < PE_NUM; p++) begin
            if (pe_sel_q == PeW'(p)) begin
                rd_pair = idx_rd_data_i[p*2*IDX_W +: 2*IDX_W];
            end
        end
    end

    assign wr_pair = swap_q ? {rd_pair[IDX_W-1:0], rd_pair[2*IDX_W-1:IDX_W]} : rd_pair;

    always_comb begin
        idx_rd_en_o = '0;
        if (state_q == StRead) begin
            for (int p = 0; p < PE_NUM; p++) begin
                if (pe_sel_q == PeW'(p)) begin
                    idx_rd_en_o[p] = 1'b1;
                end
            end
        end
    end

    idx_word_packer #(
        .LaneW (LaneW)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (pack_clr),
        .wr_en_i   (cap_vld_q),
        .wr_lane_i (cap_lane_q),
        .wr_data_i (wr_pair),
        .word_o    (word)
    );

    assign idx_rd_addr_o = addr_q;
    assign done_o        = done_q;
    assign ddr.data      = word;
    assign ddr.valid     = (state_q == StSend);
    assign ddr.last      = (state_q == StSend) && last_word_q;

endmodule

// File: tb/tb_ibuf2ddr.sv
// tb_ibuf2ddr: scoreboard bench for ibuf2ddr. Jobs push their expected words into a queue when
// started; a negedge monitor compares every presented word and pops it on handshake.
module tb_ibuf2ddr;
    import ibuf2ddr_pkg::*;

    localparam int unsigned IDX_DEPTH = 256;
    localparam int unsigned PE_NUM    = 32;
    localparam int unsigned B         = IDX_BATCH;
    localparam int unsigned LW        = 2 * IDX_W;

    typedef struct packed {
        logic [DDR_W-1:0] data;
        logic             last;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   ready = 1'b1;
    logic [3:0]             mode = '0;
    logic [7:0]             idx_num = '0;
    logic [4:0]             pe_sel = '0;
    logic                   done;
    logic [7:0]             rd_addr;
    logic [PE_NUM-1:0]      rd_en;
    logic [PE_NUM*LW-1:0]   rd_data = '0;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t0 = 0;

    ibuf2ddr_if #(.DataW(DDR_W)) ddr_bus ();
    assign ddr_bus.ready = ready;

    ibuf2ddr #(
        .IDX_DEPTH (IDX_DEPTH),
        .PE_NUM    (PE_NUM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .done_o         (done),
        .conf_mode_i    (mode),
        .conf_idx_num_i (idx_num),
        .conf_pe_sel_i  (pe_sel),
        .idx_rd_addr_o  (rd_addr),
        .idx_rd_en_o    (rd_en),
        .idx_rd_data_i  (rd_data),
        .ddr            (ddr_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PE 3 holds {a, ~a}; other PEs hold a distinct pattern to expose a wrong PE select.
    function automatic logic [LW-1:0] mem_word(input int p, input int a);
        logic [IDX_W-1:0] a16;
        a16 = IDX_W'(a);
        if (p == 3) return {a16, ~a16};
        return {16'hB000 + IDX_W'(p), a16 ^ 16'h5A5A};
    endfunction

    always @(posedge clk) begin
        for (int p = 0; p < PE_NUM; p++) begin
            if (rd_en[p]) rd_data[p*LW +: LW] <= mem_word(p, int'(rd_addr));
        end
    end

    task automatic chk(input string nm, input logic [DDR_W-1:0] act, input logic [DDR_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic push_job(input int idx, input int pe, input bit swap);
        int total;
        total = idx + 1;
        for (int first = 0; first < total; first += B) begin
            exp_t e;
            logic [LW-1:0] lane;
            e.data = '0;
            for (int k = 0; k < B; k++) begin
                if (first + k < total) begin
                    lane = mem_word(pe, (first + k) % IDX_DEPTH);
                    if (swap) lane = {lane[IDX_W-1:0], lane[LW-1:IDX_W]};
                    e.data[k*LW +: LW] = lane;
                end
            end
            e.last = (first + B >= total);
            exp_q.push_back(e);
        end
    endtask

    // Starts a job, then scrambles the conf inputs to prove they were latched.
    task automatic start_job(input int idx, input int pe, input logic [3:0] m);
        @(posedge clk); #1;
        idx_num = 8'(idx);
        pe_sel  = 5'(pe);
        mode    = m;
        start   = 1'b1;
        push_job(idx, pe, m[2:1] == 2'b01);
        @(posedge clk); #1;
        start   = 1'b0;
        idx_num = 8'hff;
        pe_sel  = 5'd7;
        mode    = m ^ 4'b0010;
        t0      = cyc;
    endtask

    task automatic wait_done(input string nm, input int exp_cyc);
        int n;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk(nm, done ? (cyc - t0) : -1, exp_cyc);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!ddr_bus.valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, ddr_bus.valid, 1);
    endtask

    // Monitor: every presented word must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && ddr_bus.valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", exp_q.size(), 1);
            end else begin
                chk("word_data", ddr_bus.data, exp_q[0].data);
                chk("word_last", ddr_bus.last, exp_q[0].last);
                chk("no_read_in_send", rd_en, 0);
                if (ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 1);
        chk("rst_valid", ddr_bus.valid, 0);
        chk("rst_last", ddr_bus.last, 0);
        chk("rst_en", rd_en, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", ddr_bus.data, 0);
        rst_n = 1'b1;

        // Single full word, with read-port timing.
        start_job(7, 3, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_en", rd_en, 32'h0000_0008);
            chk("t1_addr", rd_addr, k);
            if (k == 0) chk("t1_done_low", done, 0);
        end
        @(negedge clk);
        chk("t1_drain_en", rd_en, 0);
        chk("t1_drain_valid", ddr_bus.valid, 0);
        wait_done("t1_cycles", 10);

        // Partial last word: 8 + 8 + 4 entries.
        start_job(19, 3, 4'b0000);
        wait_done("t2_cycles", 26);

        // Half-swap.
        start_job(7, 3, 4'b0010);
        wait_done("t3_cycles", 10);

        // Backpressure for 5 cycles on the first word.
        start_job(15, 3, 4'b0000);
        wait_valid("t4_valid");
        ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ready = 1'b1;
        wait_done("t4_cycles", 25);

        // start pulses during READ and during SEND are ignored.
        start_job(15, 3, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; idx_num = 8'd0; pe_sel = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("t5_valid");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5_cycles", 20);

        // Different PE, short job.
        start_job(2, 0, 4'b0000);
        wait_done("t6_cycles", 5);

        // Async reset in the middle of SEND.
        start_job(15, 3, 4'b0000);
        wait_valid("t7_valid");
        ready = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_done", done, 1);
        chk("t7_rst_valid", ddr_bus.valid, 0);
        chk("t7_rst_last", ddr_bus.last, 0);
        chk("t7_rst_en", rd_en, 0);
        chk("t7_rst_data", ddr_bus.data, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;

        // One entry after reset: lane 0 = {0000, FFFF}, rest zero.
        @(posedge clk); #1;
        idx_num = 8'd0; pe_sel = 5'd3; mode = 4'b0000; start = 1'b1;
        e.data = '0;
        e.data[31:0] = 32'h0000_FFFF;
        e.last = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        wait_done("t8_cycles", 3);

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
